// File: rtl/fnd_pkg.sv
// fnd_pkg: shared segment/digit-select encodings and types for FND scan checkers.
package fnd_pkg;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] DIG_ONES  = 4'b1110;
   localparam logic [3:0] DIG_TENS  = 4'b1101;
   localparam logic [3:0] DIG_HUNDS = 4'b1011;
   localparam logic [3:0] DIG_THOUS = 4'b0111;
   typedef logic [3:0] bcd_t;
   typedef enum logic {COLLECT, EMIT} fsm_t;
   function automatic logic [13:0] bcd4_to_bin(input bcd_t d3, input bcd_t d2, input bcd_t d1, input bcd_t d0);
      return 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
   endfunction
endpackage

// File: rtl/fnd_seg_decode.sv
// fnd_seg_decode: active-low 7-segment pattern to BCD, flagging blank and undecodable patterns.
module fnd_seg_decode
   import fnd_pkg::*;
(
   input  logic [6:0] seg_i,
   output bcd_t       bcd_o,
   output logic       blank_o,
   output logic       invalid_o
);
   always_comb begin
      bcd_o     = '0;
      blank_o   = 1'b0;
      invalid_o = 1'b0;
      case (seg_i)
         SEG_0:     bcd_o = 4'd0;
         SEG_1:     bcd_o = 4'd1;
         SEG_2:     bcd_o = 4'd2;
         SEG_3:     bcd_o = 4'd3;
         SEG_4:     bcd_o = 4'd4;
         SEG_5:     bcd_o = 4'd5;
         SEG_6:     bcd_o = 4'd6;
         SEG_7:     bcd_o = 4'd7;
         SEG_8:     bcd_o = 4'd8;
         SEG_9:     bcd_o = 4'd9;
         SEG_BLANK: blank_o = 1'b1;
         default:   invalid_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: rebuilds the value shown on a 4-digit multiplexed FND from its scan lines.
// Define FND_SEQ_CHECK_EN to enforce ones->thousands capture order and expose seq_err.
module fnd_scan_decoder
   import fnd_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 400_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  fnd_digit,
   input  logic [7:0]  fnd_data,
   output logic [13:0] value,
   output logic [15:0] digits_bcd,
   output logic        value_valid,
   output logic        frame_err,
   output logic        timeout
`ifdef FND_SEQ_CHECK_EN
   ,output logic       seq_err
`endif
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [7:0] SET_MAX = 8'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [3:0] dig_q, dig_p_q, mask_q, mask_d, err_q, err_d;
   logic [7:0] dat_q, dat_p_q, stab_q, stab_d;
   logic [TW-1:0] to_q, to_d;
   bcd_t [3:0] slot_q, slot_d;
   fsm_t state_q, state_d;
   logic [13:0] value_q;
   logic [15:0] digits_q;
   logic valid_q, ferr_q, to_pulse_q, to_pulse_d;
   logic same, legal, cap, emit, to_hit, dec_blank, dec_inv;
   logic [1:0] sidx;
   bcd_t dec_bcd;
`ifdef FND_SEQ_CHECK_EN
   logic seq_q, seq_d;
   assign seq_err = seq_q;
`endif
   fnd_seg_decode u_dec (.seg_i(dat_q[6:0]), .bcd_o(dec_bcd), .blank_o(dec_blank), .invalid_o(dec_inv));
   assign same   = {dig_q, dat_q} == {dig_p_q, dat_p_q};
   assign legal  = dig_q inside {DIG_ONES, DIG_TENS, DIG_HUNDS, DIG_THOUS};
   assign sidx   = (dig_q == DIG_ONES) ? 2'd0 : (dig_q == DIG_TENS) ? 2'd1 : (dig_q == DIG_HUNDS) ? 2'd2 : 2'd3;
   assign cap    = same && legal && stab_q == SET_MAX - 8'd1;
   assign stab_d = !same ? 8'd1 : (stab_q == SET_MAX) ? stab_q : stab_q + 8'd1;
   assign emit   = state_q == EMIT;
   assign to_hit = to_q == TO_LAST;
   always_comb begin
      mask_d     = mask_q;
      err_d      = err_q;
      slot_d     = slot_q;
      to_d       = to_hit ? to_q : to_q + 1'b1;
      to_pulse_d = 1'b0;
`ifdef FND_SEQ_CHECK_EN
      seq_d      = 1'b0;
`endif
      if (emit) begin
         mask_d = '0;
         err_d  = '0;
      end else if (to_hit && mask_q != '0 && !cap) begin
         mask_d     = '0;
         err_d      = '0;
         to_pulse_d = 1'b1;
      end
      if (cap) begin
         to_d = '0;
`ifdef FND_SEQ_CHECK_EN
         // in order means every lower slot is already captured and nothing above it
         seq_d = mask_d != (4'b0001 << sidx) - 4'd1;
         if (seq_d) begin
            mask_d = '0;
            err_d  = '0;
         end
         if (!seq_d || sidx == 2'd0) begin
`else
         begin
`endif
            mask_d[sidx] = 1'b1;
            err_d[sidx]  = dec_inv;
            slot_d[sidx] = dec_blank ? 4'd0 : dec_bcd;
         end
      end
      state_d = (mask_d == 4'hF) ? EMIT : COLLECT;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dig_q      <= '0;
         dig_p_q    <= '0;
         dat_q      <= '0;
         dat_p_q    <= '0;
         stab_q     <= '0;
         to_q       <= '0;
         mask_q     <= '0;
         err_q      <= '0;
         slot_q     <= '0;
         state_q    <= COLLECT;
         value_q    <= '0;
         digits_q   <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         to_pulse_q <= 1'b0;
`ifdef FND_SEQ_CHECK_EN
         seq_q      <= 1'b0;
`endif
      end else begin
         dig_q      <= fnd_digit;
         dat_q      <= fnd_data;
         dig_p_q    <= dig_q;
         dat_p_q    <= dat_q;
         stab_q     <= stab_d;
         to_q       <= to_d;
         mask_q     <= mask_d;
         err_q      <= err_d;
         slot_q     <= slot_d;
         state_q    <= state_d;
         valid_q    <= emit;
         to_pulse_q <= to_pulse_d;
`ifdef FND_SEQ_CHECK_EN
         seq_q      <= seq_d;
`endif
         if (emit) begin
            value_q  <= bcd4_to_bin(slot_q[3], slot_q[2], slot_q[1], slot_q[0]);
            digits_q <= slot_q;
            ferr_q   <= |err_q;
         end
      end
   end
   assign value       = value_q;
   assign digits_bcd  = digits_q;
   assign value_valid = valid_q;
   assign frame_err   = ferr_q;
   assign timeout     = to_pulse_q;
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb_fnd_scan_decoder: directed scans checked against a run-length/frame model of the decoder.
module tb_fnd_scan_decoder;
   localparam int S = 4;
   localparam int T = 40;
   logic clk = 1'b0, reset = 1'b1;
   logic [3:0] fnd_digit = 4'hF;
   logic [7:0] fnd_data = 8'hFF;
   logic [13:0] value;
   logic [15:0] digits_bcd;
   logic value_valid, frame_err, timeout;
`ifdef FND_SEQ_CHECK_EN
   logic seq_err;
`endif
   int n_cmp = 0, n_bad = 0, dut_valids = 0, dut_tos = 0;
   logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   fnd_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .fnd_digit(fnd_digit), .fnd_data(fnd_data),
      .value(value), .digits_bcd(digits_bcd), .value_valid(value_valid),
      .frame_err(frame_err), .timeout(timeout)
`ifdef FND_SEQ_CHECK_EN
      ,.seq_err(seq_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int seg_val(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (segs[i] == s) return i;
      return (s == 7'h7F) ? 0 : -1;
   endfunction

   function automatic int dig_idx(input logic [3:0] d);
      case (d)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] sb(input int d);
      return {1'b1, segs[d]};
   endfunction

   // model: a pair captures when its run of identical samples reaches S
   logic [11:0] m_last, m_pcap_v, cur;
   int m_run, n, m_lastcap, m_slot[4], idx, v;
   bit m_pcap, m_pemit;
   logic [3:0] m_mask, m_err;
   int e_value, e_bcd, e_valid, e_ferr, e_to;

   always begin
      @(posedge clk);
      if (reset) begin
         m_last = '0; m_run = 0; m_pcap = 0; m_pcap_v = '0; m_pemit = 0;
         n = 0; m_lastcap = 0; m_mask = '0; m_err = '0;
         for (int i = 0; i < 4; i++) m_slot[i] = 0;
         e_value = 0; e_bcd = 0; e_valid = 0; e_ferr = 0; e_to = 0;
      end else begin
         n++;
         e_valid = 0;
         e_to = 0;
         if (m_pemit) begin
            e_value = m_slot[3] * 1000 + m_slot[2] * 100 + m_slot[1] * 10 + m_slot[0];
            e_bcd = (m_slot[3] << 12) | (m_slot[2] << 8) | (m_slot[1] << 4) | m_slot[0];
            e_ferr = (m_err != 0);
            e_valid = 1;
            m_mask = '0; m_err = '0; m_pemit = 0;
         end else if (!m_pcap && n - m_lastcap == T && m_mask != 0) begin
            e_to = 1;
            m_mask = '0; m_err = '0;
         end
         if (m_pcap) begin
            idx = dig_idx(m_pcap_v[11:8]);
            v = seg_val(m_pcap_v[6:0]);
            m_slot[idx] = (v < 0) ? 0 : v;
            m_err[idx] = (v < 0);
            m_mask[idx] = 1'b1;
            m_lastcap = n;
            if (m_mask == 4'hF) m_pemit = 1;
         end
         cur = {fnd_digit, fnd_data};
         m_run = (cur == m_last) ? m_run + 1 : 1;
         m_last = cur;
         m_pcap = (m_run == S) && dig_idx(fnd_digit) >= 0;
         m_pcap_v = cur;
      end
      #1;
      check("value", int'(value), e_value);
      check("digits_bcd", int'(digits_bcd), e_bcd);
      check("value_valid", int'(value_valid), e_valid);
      check("frame_err", int'(frame_err), e_ferr);
      check("timeout", int'(timeout), e_to);
      if (value_valid === 1'b1) dut_valids++;
      if (timeout === 1'b1) dut_tos++;
   end

   task automatic hold(input logic [3:0] d, input logic [7:0] s, input int cyc);
      fnd_digit = d;
      fnd_data = s;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b3, input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0, input int cyc);
      hold(4'b1110, b0, cyc);
      hold(4'b1101, b1, cyc);
      hold(4'b1011, b2, cyc);
      hold(4'b0111, b3, cyc);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      hold(4'hF, 8'hFF, 4);
      check("lit_rst_value", int'(value), 0);
      check("lit_rst_valids", dut_valids, 0);
      frame(sb(1), sb(2), sb(3), sb(4), 8);
      hold(4'hF, 8'hFF, 4);
      check("lit_1234_value", int'(value), 1234);
      check("lit_1234_bcd", int'(digits_bcd), 16'h1234);
      check("lit_1234_ferr", int'(frame_err), 0);
      check("lit_1234_valids", dut_valids, 1);
      frame(sb(5), sb(6), sb(7), sb(8), S - 1);
      hold(4'hF, 8'hFF, 4);
      check("lit_short_valids", dut_valids, 1);
      check("lit_short_value", int'(value), 1234);
      frame(sb(0), sb(0), sb(0), sb(0), 5);
      hold(4'hF, 8'hFF, 4);
      check("lit_zero_value", int'(value), 0);
      check("lit_zero_valids", dut_valids, 2);
      frame(sb(9), sb(9), sb(9), sb(9), 8);
      hold(4'hF, 8'hFF, 4);
      check("lit_9999_value", int'(value), 9999);
      for (int i = 0; i < 10; i++) frame(8'hFF, 8'hFF, sb(4), sb(2), 6);
      hold(4'hF, 8'hFF, 4);
      check("lit_42_value", int'(value), 42);
      check("lit_42_ferr", int'(frame_err), 0);
      check("lit_42_valids", dut_valids, 13);
      frame(sb(5), sb(6), 8'hFE, sb(8), 8);
      hold(4'hF, 8'hFF, 4);
      check("lit_err_value", int'(value), 5608);
      check("lit_err_bcd", int'(digits_bcd), 16'h5608);
      check("lit_err_ferr", int'(frame_err), 1);
      check("lit_err_valids", dut_valids, 14);
      hold(4'b1110, sb(1), 8);
      hold(4'b1101, sb(2), 8);
      hold(4'hF, 8'hFF, T + 10);
      check("lit_to_count", dut_tos, 1);
      check("lit_to_value", int'(value), 5608);
      check("lit_to_valids", dut_valids, 14);
      hold(4'b1110, sb(1), 8);
      hold(4'b1101, sb(2), 8);
      hold(4'b1011, sb(3), 2);
      reset = 1'b1;
      hold(4'b1011, sb(3), 2);
      check("lit_mrst_value", int'(value), 0);
      check("lit_mrst_ferr", int'(frame_err), 0);
      reset = 1'b0;
      hold(4'b0111, sb(4), 8);
      hold(4'hF, 8'hFF, T + 10);
      check("lit_mrst_valids", dut_valids, 14);
      check("lit_mrst_bcd", int'(digits_bcd), 0);
      check("lit_mrst_tos", dut_tos, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
